// File: rtl/period_meter_pkg.sv
// ============================================================================
//  period_meter_pkg
//  Types and default widths shared by the period meter and its sub-module.
//  Revision: 1.0
// ============================================================================
`default_nettype none

`include "period_meter_defs.svh"

package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = `PM_STATE_IDLE,
    ST_ARM     = `PM_STATE_ARM,
    ST_MEASURE = `PM_STATE_MEASURE
  } state_e;

  localparam int COUNT_WIDTH_DEFAULT = `PM_COUNT_WIDTH_DEFAULT;
  localparam int SYNC_STAGES_DEFAULT = `PM_SYNC_STAGES_DEFAULT;

endpackage

`default_nettype wire

// File: rtl/edge_sync.sv
// ============================================================================
//  edge_sync
//  Multi-flop synchronizer followed by a registered rising-edge detector.
//  Ports:
//    clk  - clock
//    rst  - asynchronous active-high reset
//    in   - asynchronous input
//    rise - one-cycle pulse per rising edge of the synchronized input
//  Revision: 1.0
// ============================================================================
`default_nettype none

module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in};
    prev_d = sync_q[SYNC_STAGES-1];
    // Registered so the pulse is glitch-free and latency stays fixed.
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

`default_nettype wire

// File: rtl/period_meter_defs.svh
// ============================================================================
//  period_meter_defs.svh
//  Shared definitions for the period meter: FSM state encodings and the
//  default parameter widths. Guarded so it can be included more than once.
//  Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef PERIOD_METER_DEFS_SVH
`define PERIOD_METER_DEFS_SVH

`define PM_STATE_IDLE          2'd0
`define PM_STATE_ARM           2'd1
`define PM_STATE_MEASURE       2'd2

`define PM_COUNT_WIDTH_DEFAULT 16
`define PM_SYNC_STAGES_DEFAULT 2

`endif

`default_nettype wire

// File: rtl/period_meter.sv
// ============================================================================
//  period_meter
//  Measures the rising-edge-to-rising-edge period of an asynchronous signal
//  in clk cycles and hands each result out over a valid/ready handshake.
//  Ports:
//    clk, rst  - clock, asynchronous active-high reset
//    enable    - measurement running when high
//    sig_in    - asynchronous signal being measured
//    ready     - consumer accepts the result on ready & valid
//    period    - measured period (all ones when saturated)
//    saturated - true period was at least 2^COUNT_WIDTH-1 cycles
//    valid     - period/saturated hold an unaccepted result
//    overrun   - sticky: a completed measurement was dropped
//  Revision: 1.0
// ============================================================================
`default_nettype none

module period_meter
  import period_meter_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sig_in,
  input  logic                   ready,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   saturated,
  output logic                   valid,
  output logic                   overrun
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic                   sat_q, sat_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   rise;
  logic                   capture;
  logic                   accept;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .in   (sig_in),
    .rise (rise)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_ARM;
        ST_ARM:     if (rise) state_d = ST_MEASURE;
        ST_MEASURE: state_d = ST_MEASURE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Counter, result capture and handshake
  always_comb begin
    capture   = enable && (state_q == ST_MEASURE) && rise;
    accept    = valid_q && ready;
    count_d   = count_q;
    period_d  = period_q;
    sat_d     = sat_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (!enable || state_q == ST_IDLE) begin
      count_d = '0;
    end else if (state_q == ST_ARM) begin
      count_d = rise ? CNT_ONE : '0;
    end else if (rise) begin
      count_d = CNT_ONE;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + CNT_ONE;
    end

    if (capture) begin
      // A slot is free if nothing is pending or the pending result leaves now.
      if (!valid_q || accept) begin
        period_d = count_q;
        sat_d    = (count_q == CNT_MAX);
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      period_q  <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      period_q  <= period_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign period    = period_q;
  assign saturated = sat_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_period_meter.sv
// ============================================================================
//  tb_period_meter
//  Self-checking bench: two instances (16-bit/2-stage and 4-bit/3-stage)
//  share stimulus and are compared against an edge-time reference model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        sig_in = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] period0;
  logic [3:0]  period1;
  logic        sat0, sat1, valid0, valid1, overrun0, overrun1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  period_meter #(.COUNT_WIDTH(16), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in), .ready(ready),
    .period(period0), .saturated(sat0), .valid(valid0), .overrun(overrun0));

  period_meter #(.COUNT_WIDTH(4), .SYNC_STAGES(3)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .sig_in(sig_in), .ready(ready),
    .period(period1), .saturated(sat1), .valid(valid1), .overrun(overrun1));

  // ---------------- reference model ----------------
  // hist[k] = sig_in value sampled k posedges ago (0 = this posedge).
  // A rising edge sampled at posedge r is acted on at posedge r+S+1.
  int          mw [2] = '{16, 4};
  int          ms [2] = '{2, 3};
  bit          hist [0:15];
  int          n = 0;
  int          m_phase [2];   // 0 disabled, 1 waiting for first edge, 2 have reference edge
  int          m_last [2];
  logic [15:0] m_per [2];
  bit          m_sat [2], m_vld [2], m_ovr [2];

  task automatic model_reset();
    for (int k = 0; k < 16; k++) hist[k] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_last[d] = 0; m_per[d] = '0;
      m_sat[d] = 1'b0; m_vld[d] = 1'b0; m_ovr[d] = 1'b0;
    end
  endtask

  task automatic model_tick(input bit en, input bit s, input bit rdy);
    n++;
    for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    for (int d = 0; d < 2; d++) begin
      bit edge_seen, cap, acc;
      int dt, maxv;
      edge_seen = hist[ms[d]+1] && !hist[ms[d]+2];
      cap = 1'b0; dt = 0;
      maxv = (1 << mw[d]) - 1;
      if (!en) m_phase[d] = 0;
      else if (m_phase[d] == 0) m_phase[d] = 1;
      else if (edge_seen) begin
        if (m_phase[d] == 2) begin cap = 1'b1; dt = n - m_last[d]; end
        m_phase[d] = 2;
        m_last[d] = n;
      end
      acc = m_vld[d] && rdy;
      if (cap) begin
        if (!m_vld[d] || acc) begin
          m_vld[d] = 1'b1;
          m_sat[d] = (dt >= maxv);
          m_per[d] = 16'((dt >= maxv) ? maxv : dt);
        end else m_ovr[d] = 1'b1;
      end else if (acc) m_vld[d] = 1'b0;
    end
  endtask

  function automatic logic [18:0] exp_pack(input int d);
    return {m_ovr[d], m_vld[d], m_sat[d], m_per[d]};
  endfunction
  function automatic logic [18:0] got0();
    return {overrun0, valid0, sat0, period0};
  endfunction
  function automatic logic [18:0] got1();
    return {overrun1, valid1, sat1, 12'h000, period1};
  endfunction

  // Drive one cycle from a negedge, advance the model, return at next negedge.
  task automatic cyc(input bit en, input bit s, input bit rdy);
    enable = en; sig_in = s; ready = rdy;
    model_tick(en, s, rdy);
    @(negedge clk);
  endtask

  task automatic settle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (got0() !== 19'd0) begin errors++; $display("FAIL reset dut0 got=%h exp=0", got0()); end
    checks++;
    if (got1() !== 19'd0) begin errors++; $display("FAIL reset dut1 got=%h exp=0", got1()); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_periodic();
    int pulses = 0;
    bit prev_v = 1'b0;
    settle(4);
    for (int i = 0; i < 70; i++) begin
      cyc(1'b1, (i < 60) && ((i % 10) < 5), 1'b1);
      checks++;
      if (got0() !== exp_pack(0)) begin errors++; $display("FAIL periodic dut0 i=%0d got=%h exp=%h", i, got0(), exp_pack(0)); end
      checks++;
      if (got1() !== exp_pack(1)) begin errors++; $display("FAIL periodic dut1 i=%0d got=%h exp=%h", i, got1(), exp_pack(1)); end
      if (valid0) begin
        pulses++;
        checks++;
        if (period0 !== 16'd10 || sat0 !== 1'b0 || prev_v) begin
          errors++; $display("FAIL periodic_value i=%0d got=%0d/%0d held=%0d exp=10/0/0", i, period0, sat0, prev_v);
        end
      end
      prev_v = valid0;
    end
    checks++;
    if (pulses != 5) begin errors++; $display("FAIL periodic_pulses got=%0d exp=5", pulses); end
  endtask

  task automatic test_saturation();
    int rises [7] = '{0, 20, 40, 60, 67, 74, 81};
    int exp_p [6] = '{15, 15, 15, 7, 7, 7};
    int idx = 0;
    settle(4);
    for (int i = 0; i < 95; i++) begin
      bit s = 1'b0;
      for (int r = 0; r < 7; r++) if (i >= rises[r] && i < rises[r] + 3) s = 1'b1;
      cyc(1'b1, s, 1'b1);
      checks++;
      if (got0() !== exp_pack(0)) begin errors++; $display("FAIL saturation dut0 i=%0d got=%h exp=%h", i, got0(), exp_pack(0)); end
      checks++;
      if (got1() !== exp_pack(1)) begin errors++; $display("FAIL saturation dut1 i=%0d got=%h exp=%h", i, got1(), exp_pack(1)); end
      if (valid1) begin
        checks++;
        if (idx >= 6 || int'(period1) != exp_p[idx] || sat1 !== (exp_p[idx] == 15)) begin
          errors++; $display("FAIL saturation_value idx=%0d got=%0d/%0d", idx, period1, sat1);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 6) begin errors++; $display("FAIL saturation_count got=%0d exp=6", idx); end
  endtask

  task automatic test_same_cycle();
    settle(4);
    for (int i = 0; i < 35; i++) begin
      bit s = (i < 3) || (i >= 8 && i < 11) || (i >= 20 && i < 23);
      cyc(1'b1, s, i == 23);
      checks++;
      if (got0() !== exp_pack(0)) begin errors++; $display("FAIL same_cycle dut0 i=%0d got=%h exp=%h", i, got0(), exp_pack(0)); end
      checks++;
      if (got1() !== exp_pack(1)) begin errors++; $display("FAIL same_cycle dut1 i=%0d got=%h exp=%h", i, got1(), exp_pack(1)); end
      if (i == 22) begin
        checks++;
        if (valid0 !== 1'b1 || period0 !== 16'd8) begin errors++; $display("FAIL same_cycle_before got=%0d/%0d exp=1/8", valid0, period0); end
      end
      if (i == 23) begin
        checks++;
        if (valid0 !== 1'b1 || period0 !== 16'd12 || overrun0 !== 1'b0) begin
          errors++; $display("FAIL same_cycle_after got=%0d/%0d/%0d exp=1/12/0", valid0, period0, overrun0);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    settle(4);
    for (int i = 0; i < 35; i++) begin
      cyc(1'b1, (i % 8) < 3 && i < 27, 1'b0);
      checks++;
      if (got0() !== exp_pack(0)) begin errors++; $display("FAIL backpressure dut0 i=%0d got=%h exp=%h", i, got0(), exp_pack(0)); end
      checks++;
      if (got1() !== exp_pack(1)) begin errors++; $display("FAIL backpressure dut1 i=%0d got=%h exp=%h", i, got1(), exp_pack(1)); end
      if (i == 18 || i == 19) begin
        checks++;
        if (overrun0 !== (i == 19)) begin errors++; $display("FAIL backpressure_overrun i=%0d got=%0d exp=%0d", i, overrun0, i == 19); end
      end
    end
    checks++;
    if (valid0 !== 1'b1 || period0 !== 16'd8 || overrun0 !== 1'b1) begin
      errors++; $display("FAIL backpressure_hold got=%0d/%0d/%0d exp=1/8/1", valid0, period0, overrun0);
    end
    cyc(1'b1, 1'b0, 1'b1);
    checks++;
    if (valid0 !== 1'b0 || overrun0 !== 1'b1) begin
      errors++; $display("FAIL backpressure_release got=%0d/%0d exp=0/1", valid0, overrun0);
    end
  endtask

  task automatic test_latency();
    int lat = -1;
    settle(4);
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, (i < 3) || (i >= 10 && i < 13), 1'b1);
      checks++;
      if (got1() !== exp_pack(1)) begin errors++; $display("FAIL latency dut1 i=%0d got=%h exp=%h", i, got1(), exp_pack(1)); end
      if (i >= 10 && valid1 && lat < 0) lat = i - 10 + 1;
    end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL latency_cycles got=%0d exp=5", lat); end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    settle(4);
    for (int i = 0; i < 8; i++) cyc(1'b1, i < 3, 1'b1);
    #1 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (got0() !== 19'd0) begin errors++; $display("FAIL reset_mid dut0 got=%h exp=0", got0()); end
    checks++;
    if (got1() !== 19'd0) begin errors++; $display("FAIL reset_mid dut1 got=%h exp=0", got1()); end
    #1 rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, (i >= 4 && i < 7) || (i >= 13 && i < 16), 1'b1);
      checks++;
      if (got0() !== exp_pack(0)) begin errors++; $display("FAIL reset_mid dut0 i=%0d got=%h exp=%h", i, got0(), exp_pack(0)); end
      checks++;
      if (got1() !== exp_pack(1)) begin errors++; $display("FAIL reset_mid dut1 i=%0d got=%h exp=%h", i, got1(), exp_pack(1)); end
      if (valid0 && first < 0) first = int'(period0);
    end
    checks++;
    if (first != 9) begin errors++; $display("FAIL reset_mid_period got=%0d exp=9", first); end
  endtask

  task automatic test_random();
    bit s = 1'b0;
    int hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin s = !s; hold = $urandom_range(1, 22); end
      hold--;
      cyc($urandom_range(0, 60) != 0, s, $urandom_range(0, 1) == 1);
      checks++;
      if (got0() !== exp_pack(0)) begin errors++; $display("FAIL random dut0 i=%0d got=%h exp=%h", i, got0(), exp_pack(0)); end
      checks++;
      if (got1() !== exp_pack(1)) begin errors++; $display("FAIL random dut1 i=%0d got=%h exp=%h", i, got1(), exp_pack(1)); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_periodic();
    test_saturation();
    test_same_cycle();
    test_backpressure();
    test_latency();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
